// File: rtl/demod_pkg.sv
// Shared types and sizes for the IQ bin histogram: FSM encoding, analysis
// modes, histogram geometry and the bin address packing helper.
package demod_pkg;

   localparam int HIST_DEPTH = 1024;
   localparam int IDX_W      = 5;
   localparam int ADDR_W     = 10;
   localparam int DIFF_W     = 33;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_CALC,
      ST_UPD_RD,
      ST_UPD_WR
   } state_e;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_HIST   = 2'd1,
      MODE_REPORT = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   function automatic logic [ADDR_W-1:0] bin_addr(input logic [IDX_W-1:0] y_idx,
                                                  input logic [IDX_W-1:0] x_idx);
      return {y_idx, x_idx};
   endfunction

endpackage

// File: rtl/iq_bin_histogram_if.sv
// Host-side bundle of the histogram: sample input, bin configuration,
// readout port and status/statistics outputs.
interface iq_bin_histogram_if #(
   parameter int CNT_W  = 16,
   parameter int DROP_W = 16
);
   import demod_pkg::*;

   logic                     iq_valid;
   logic signed [31:0]       i_val;
   logic signed [31:0]       q_val;
   logic [1:0]               analyze_mode;
   logic [15:0]              x_bin_width;
   logic [15:0]              y_bin_width;
   logic [IDX_W-1:0]         x_bin_num;
   logic [IDX_W-1:0]         y_bin_num;
   logic signed [15:0]       x_bin_min;
   logic signed [15:0]       y_bin_min;
   logic                     clear;
   logic                     rd_en;
   logic [ADDR_W-1:0]        rd_addr;
   logic [CNT_W-1:0]         rd_data;
   logic                     busy;
   logic                     clear_busy;
   logic                     bin_valid;
   logic [IDX_W-1:0]         bin_x;
   logic [IDX_W-1:0]         bin_y;
   logic [31:0]              total_count;
   logic [DROP_W-1:0]        oor_count;
   logic [DROP_W-1:0]        drop_count;

   modport master (
      output iq_valid, i_val, q_val, analyze_mode,
             x_bin_width, y_bin_width, x_bin_num, y_bin_num, x_bin_min, y_bin_min,
             clear, rd_en, rd_addr,
      input  rd_data, busy, clear_busy, bin_valid, bin_x, bin_y,
             total_count, oor_count, drop_count
   );

   modport slave (
      input  iq_valid, i_val, q_val, analyze_mode,
             x_bin_width, y_bin_width, x_bin_num, y_bin_num, x_bin_min, y_bin_min,
             clear, rd_en, rd_addr,
      output rd_data, busy, clear_busy, bin_valid, bin_x, bin_y,
             total_count, oor_count, drop_count
   );

endinterface

// File: rtl/bin_index_calc.sv
// One axis of the bin search: repeated subtraction of the bin width from
// (value - min). The first step is folded into the load cycle.
module bin_index_calc
   import demod_pkg::*;
(
   input  logic                 clk100,
   input  logic                 load_i,
   input  logic                 run_i,
   input  logic signed [31:0]   value_i,
   input  logic signed [15:0]   min_i,
   input  logic [15:0]          width_i,
   input  logic [IDX_W-1:0]     num_i,
   output logic [IDX_W-1:0]     idx_o,
   output logic                 done_o,
   output logic                 oor_o
);

   logic signed [DIFF_W-1:0] d_q, d_cur, d_nxt, d0, width_s;
   logic [15:0]              width_q, width_cur;
   logic [IDX_W-1:0]         num_q, num_cur, idx_q, idx_cur, idx_nxt;
   logic                     bad_q, bad_cur, step;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      d0        = $signed({value_i[31], value_i}) - $signed({{17{min_i[15]}}, min_i});
      d_cur     = d_q;
      idx_cur   = idx_q;
      width_cur = width_q;
      num_cur   = num_q;
      bad_cur   = bad_q;
      if (load_i) begin
         d_cur     = d0;
         idx_cur   = '0;
         width_cur = width_i;
         num_cur   = num_i;
         bad_cur   = d0[DIFF_W-1] || (width_i == 16'd0);
      end
      width_s = $signed({17'd0, width_cur});
      step    = !bad_cur && (d_cur >= width_s) && (idx_cur < num_cur);
      d_nxt   = step ? d_cur - width_s : d_cur;
      idx_nxt = step ? idx_cur + IDX_W'(1) : idx_cur;
      // Done/out-of-range look at the post-step value so the FSM leaves CALC on the last step.
      done_o  = bad_cur || (d_nxt < width_s) || (idx_nxt == num_cur);
      oor_o   = bad_cur || (idx_nxt == num_cur);
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk100) begin
      if (load_i || run_i) begin
         d_q     <= d_nxt;
         idx_q   <= idx_nxt;
         bad_q   <= bad_cur;
         width_q <= width_cur;
         num_q   <= num_cur;
      end
   end

   assign idx_o = idx_q;

endmodule

// File: rtl/iq_bin_histogram.sv
// 2-D histogram of demodulated IQ samples: bin search per axis, then a
// read-modify-write of a saturating counter in a 1024-entry block RAM.
module iq_bin_histogram
   import demod_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int DROP_W = 16
) (
   input  logic               clk100,
   input  logic               reset,
   iq_bin_histogram_if.slave  bus
);

   state_e              state_q, state_d;
   mode_e               mode_q;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic [31:0]         total_q;
   logic [DROP_W-1:0]   oor_q, drop_q;
   logic [IDX_W-1:0]    bin_x_q, bin_y_q;
   logic [CNT_W-1:0]    upd_rd_q, rd_data_q;
   logic [CNT_W-1:0]    mem [HIST_DEPTH];

   logic                accept, calc_run, upd_commit, oor_exit;
   logic                x_done, x_oor, y_done, y_oor;
   logic [IDX_W-1:0]    x_idx, y_idx;
   logic [ADDR_W-1:0]   hist_addr, mem_waddr;
   logic [CNT_W-1:0]    mem_wdata;
   logic                mem_we;

   assign accept    = (state_q == ST_IDLE) && bus.iq_valid && !bus.clear &&
                      (bus.analyze_mode inside {MODE_HIST, MODE_REPORT});
   assign calc_run  = (state_q == ST_CALC);
   assign hist_addr = bin_addr(y_idx, x_idx);

   bin_index_calc u_x_calc (
      .clk100  (clk100),
      .load_i  (accept),
      .run_i   (calc_run),
      .value_i (bus.i_val),
      .min_i   (bus.x_bin_min),
      .width_i (bus.x_bin_width),
      .num_i   (bus.x_bin_num),
      .idx_o   (x_idx),
      .done_o  (x_done),
      .oor_o   (x_oor)
   );

   bin_index_calc u_y_calc (
      .clk100  (clk100),
      .load_i  (accept),
      .run_i   (calc_run),
      .value_i (bus.q_val),
      .min_i   (bus.y_bin_min),
      .width_i (bus.y_bin_width),
      .num_i   (bus.y_bin_num),
      .idx_o   (y_idx),
      .done_o  (y_done),
      .oor_o   (y_oor)
   );

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      if (bus.clear) begin
         state_d    = ST_CLEAR;
         clr_addr_d = '0;
      end else begin
         unique case (state_q)
            ST_CLEAR: begin
               clr_addr_d = clr_addr_q + ADDR_W'(1);
               if (clr_addr_q == ADDR_W'(HIST_DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE:   if (accept) state_d = ST_CALC;
            ST_CALC:   if (x_done && y_done) state_d = (x_oor || y_oor) ? ST_IDLE : ST_UPD_RD;
            ST_UPD_RD: state_d = ST_UPD_WR;
            ST_UPD_WR: state_d = ST_IDLE;
            default:   state_d = ST_CLEAR;
         endcase
      end
   end

   // A clear or reset landing on the write cycle cancels the update entirely.
   assign upd_commit = (state_q == ST_UPD_WR) && !bus.clear && !reset;
   assign oor_exit   = calc_run && x_done && y_done && (x_oor || y_oor);

   always_comb begin
      mem_we    = upd_commit;
      mem_waddr = hist_addr;
      mem_wdata = (&upd_rd_q) ? upd_rd_q : upd_rd_q + CNT_W'(1);
      if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr_q;
         mem_wdata = '0;
      end
   end

   // NOTE: the histogram array has no reset; the CLEAR sweep entered from reset zeroes it.
   always_ff @(posedge clk100) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (state_q == ST_UPD_RD) upd_rd_q <= mem[hist_addr];
   end

   always_ff @(posedge clk100) begin
      if (reset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
         mode_q     <= MODE_OFF;
         total_q    <= '0;
         oor_q      <= '0;
         drop_q     <= '0;
         bin_x_q    <= '0;
         bin_y_q    <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         if (bus.clear) begin
            total_q <= '0;
            oor_q   <= '0;
            drop_q  <= '0;
         end else begin
            if (upd_commit) total_q <= total_q + 32'd1;
            if (oor_exit && (oor_q != '1)) oor_q <= oor_q + DROP_W'(1);
            if (bus.iq_valid && (state_q != ST_IDLE) && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
         end
         if (accept) mode_q <= mode_e'(bus.analyze_mode);
         if ((state_q == ST_UPD_RD) && (mode_q == MODE_REPORT) && !bus.clear) begin
            bin_x_q <= x_idx;
            bin_y_q <= y_idx;
         end
         // Read-first: a same-edge write to rd_addr is not visible until the next read.
         if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
      end
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.clear_busy  = (state_q == ST_CLEAR);
   assign bus.bin_valid   = (state_q == ST_UPD_WR) && (mode_q == MODE_REPORT);
   assign bus.bin_x       = bin_x_q;
   assign bus.bin_y       = bin_y_q;
   assign bus.total_count = total_q;
   assign bus.oor_count   = oor_q;
   assign bus.drop_count  = drop_q;

endmodule

// File: doc/iq_bin_histogram.md
IQ_BIN_HISTOGRAM -- requirements
Module: iq_bin_histogram

Interface
REQ-001 Parameter CNT_W, 16: bin counter width in bits.
REQ-002 Parameter DROP_W, 16: width of the drop and out-of-range counters.
REQ-003 Port clk100, input, 1: sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port iq_valid, input, 1: qualifies i_val and q_val for one cycle.
REQ-006 Ports i_val and q_val, input, 32 each: signed demodulated I and Q values.
REQ-007 Port analyze_mode, input, 2: 0 = off, 1 = histogram, 2 = histogram plus bin report, 3 = treated as 0.
REQ-008 Ports x_bin_width and y_bin_width, input, 16 each: unsigned bin widths.
REQ-009 Ports x_bin_num and y_bin_num, input, 5 each: number of bins per axis, 0..31.
REQ-010 Ports x_bin_min and y_bin_min, input, 16 each: signed lower edge of bin 0.
REQ-011 Port clear, input, 1: single-cycle request to zero every bin.
REQ-012 Ports rd_en (input, 1), rd_addr (input, 10) and rd_data (output, CNT_W): histogram readout; rd_addr = {y_idx, x_idx}.
REQ-013 Ports busy and clear_busy, output, 1 each: FSM not in IDLE; clear sweep in progress.
REQ-014 Ports bin_valid (output, 1), bin_x (output, 5) and bin_y (output, 5): bin report.
REQ-015 Ports total_count (output, 32), oor_count (output, DROP_W) and drop_count (output, DROP_W): statistics counters.

Function
REQ-016 The FSM SHALL have states CLEAR, IDLE, CALC, UPD_RD and UPD_WR.
REQ-017 In IDLE, iq_valid with analyze_mode 1 or 2 SHALL latch the sample and all bin configuration, then enter CALC; in all other modes iq_valid SHALL be ignored.
REQ-018 In CALC, per axis: d = value − min, sign-extended to 33 bits.
  - If d < 0 or width = 0, the sample is out of range.
  - Otherwise, each cycle, while d ≥ width and idx < num: d −= width and idx += 1.
  - An axis is done when d < width or idx = num.
  - idx = num means out of range.
  - The two axes SHALL run concurrently.
REQ-019 CALC SHALL exit when both axes are done, taking at most 32 cycles.
  - Out of range on either axis: increment oor_count (saturating) and return to IDLE.
  - Otherwise: go to UPD_RD.
REQ-020 UPD_RD SHALL read the counter at address {y_idx, x_idx}.
REQ-021 UPD_WR SHALL write the counter value + 1, saturating at all-ones; increment total_count (wrapping); and return to IDLE.
REQ-022 In mode 2, bin_valid SHALL pulse for 1 cycle in UPD_WR with bin_x and bin_y holding the indices; bin_x and bin_y SHALL hold their values between pulses.
REQ-023 iq_valid arriving while state ≠ IDLE SHALL be dropped and SHALL increment drop_count (saturating).
REQ-024 Readout: rd_data SHALL be valid 1 cycle after rd_en and SHALL hold between reads.
  - On an address collision with UPD_WR, rd_data SHALL return the old value (read-first).
REQ-025 clear asserted in any state SHALL abort any in-progress sample.
  - The FSM SHALL enter CLEAR, zero addresses 0..1023 at one per cycle (1024 cycles), then go to IDLE.
  - total_count, oor_count and drop_count SHALL be zeroed on entry to CLEAR.
  - clear while already in CLEAR SHALL restart the sweep at address 0.
REQ-026 During CLEAR, iq_valid SHALL count as a drop, and rd_data SHALL be undefined.

Reset
REQ-027 reset SHALL force CLEAR at address 0.
  - busy = 1 and clear_busy = 1.
  - bin_valid = 0, bin_x = 0, bin_y = 0.
  - total_count, oor_count, drop_count = 0.
  - rd_data = 0.
REQ-028 reset asserted mid-operation SHALL discard the current sample with no counter update.
REQ-029 reset SHALL take priority over clear.

Structure
REQ-030 Package demod_pkg SHALL hold the FSM state encoding, HIST_DEPTH = 1024, IDX_W = 5 and ADDR_W = 10.
REQ-031 One sub-module, bin_index_calc, SHALL be instantiated once per axis and implement REQ-018.
REQ-032 Histogram storage SHALL be a single-port-write / single-port-read inferred block RAM of 1024 × CNT_W.

Verification
REQ-033 Single-bin hit: x/y min = 0, width = 100, num = 10, mode 1, i = 250, q = 730.
  - Required: after the clear, address {7, 2} reads 1, total_count = 1, busy deasserts 8 cycles after iq_valid.
REQ-034 Out-of-range samples: same config, then i = −5, then i = 1000.
  - Required: oor_count = 2, no bin changes, total_count = 0.
REQ-035 Back-to-back input: iq_valid on 2 consecutive cycles.
  - Required: first sample binned, drop_count = 1.
REQ-036 Saturation: CNT_W = 4, 20 identical samples.
  - Required: the bin reads 15, total_count = 20.
REQ-037 Mode and clear: mode 2 gives a bin_valid pulse with correct bin_x and bin_y; mode 0 gives no effect; clear mid-CALC gives clear_busy high for 1024 cycles and all bins reading 0.
REQ-038 Reset mid-UPD_RD: required that no bin is incremented and the reset values of REQ-027 are observed.
